station_pool: RTL and testbench
===============================

STATION_POOL -- requirements
Module: station_pool

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of station entries (legal 2..8).
REQ-002 SHALL provide parameter IOP_W, default 32, internal-operation word width (legal >= 29).
REQ-003 SHALL derive localparam TAG_W = clog2(DEPTH), slot index width.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 a_rst  in  1  reset, asynchronous, active-high.
REQ-006 flush  in  1  synchronous discard of all entries.
REQ-007 id_ack  in  1  decode offers an iop this cycle.
REQ-008 id_iop  in  IOP_W  internal operation word.
REQ-009 id_iop_init  in  3  initial entry status.
REQ-010 id_pc  in  16  iop program counter.
REQ-011 id_k16  in  16  iop constant.
REQ-012 id_feed  out  1  a free entry exists; decode may present an iop.
REQ-013 lsu_wb  in  1  load data return.
REQ-014 lsu_tag  in  TAG_W  slot targeted by lsu_wb.
REQ-015 lsu_data  in  16  returned load data.
REQ-016 r_ready  out  1  a selected entry is issuable.
REQ-017 r_slot  out  TAG_W  selected entry index.
REQ-018 r_status  out  3  selected entry status.
REQ-019 r_iop  out  IOP_W  selected entry iop.
REQ-020 r_pc / r_k16  out  16 each  selected entry pc / constant.
REQ-021 r_will_complete  out  1  issuing the selected entry frees it.
REQ-022 sched_ack  in  1  scheduler accepts the selected entry.

Function
REQ-023 Entry status encoding SHALL be 000 FREE, 001 WAIT_1, 010 WAIT_2, 011 WAIT_3, 100 LOAD_0, 101 LOAD_1, 110 ALU, 111 STORE; entry ready = status[2].
REQ-024 id_feed SHALL be 1 iff at least one entry is FREE at cycle start; slots freed in the same cycle are not counted.
REQ-025 On id_feed & id_ack & ~flush, the lowest-index FREE entry SHALL capture id_iop, id_pc, id_k16 and take status id_iop_init; an id_iop_init of 000 SHALL capture nothing.
REQ-026 Transitions SHALL be:
- WAIT_1 -> LOAD_1 on matching wb.
- WAIT_2 -> ALU on matching wb.
- WAIT_3 -> STORE unconditionally.
- LOAD_0 -> WAIT_1 on issue.
- LOAD_1 -> (iop[28] ? FREE : WAIT_2) on issue.
- ALU -> (iop[23] ? STORE : FREE) on issue.
- STORE -> FREE on issue.
- Absent the event, status holds.
REQ-027 Matching wb = lsu_wb & lsu_tag == slot & slot status in {WAIT_1, WAIT_2}; it SHALL load lsu_data into that entry's k16; a wb to any other status SHALL be ignored.
REQ-028 Issue SHALL be sched_ack & r_ready, applied to entry r_slot only; sched_ack with r_ready = 0 SHALL be ignored.
REQ-029 Selection SHALL be combinational among ready entries per REQ-041; r_* SHALL mux the selected entry; with none ready, r_ready = 0 and r_slot, r_status, r_iop, r_pc, r_k16 = 0.
REQ-030 r_will_complete SHALL be 1 iff r_ready and the selected entry's issue transition targets FREE.
REQ-031 Age SHALL be a DEPTH x DEPTH matrix: on allocation of n, older[j][n] <= 1 for every non-FREE j and older[n][*] <= 0; an entry is oldest-ready iff no ready j has older[j][i].
REQ-032 Allocation, issue and wb to distinct entries in one cycle SHALL all take effect.
REQ-033 flush SHALL set all entries FREE and clear the age matrix next edge, overriding allocation, issue and wb that cycle.

Reset
REQ-034 a_rst SHALL asynchronously set every status FREE and clear iop, pc, k16 and the age matrix to 0.
REQ-035 During and after reset: id_feed = 1; r_ready, r_slot, r_status, r_iop, r_pc, r_k16, r_will_complete = 0.
REQ-036 Reset asserted mid-operation SHALL drop all in-flight entries; no output SHALL reflect pre-reset state after release.

Configuration
REQ-037 Macro STATION_POOL_AGE_ORDER_EN SHALL select the arbitration policy.
REQ-038 Defined: the age matrix SHALL be implemented.
REQ-039 Undefined: the age matrix SHALL be omitted.
REQ-040 Undefined: selection SHALL be the lowest-index ready entry.
REQ-041 Defined: selection SHALL be the oldest-ready entry.

Verification
REQ-042 Reset then allocate init=110 into slot 0, sched_ack -> r_ready=1, r_slot=0, r_will_complete=1; next cycle slot 0 FREE.
REQ-043 Allocate init=100 (iop[28]=0); issue; lsu_wb tag 0 data 0x1234 -> LOAD_1 with r_k16=0x1234; issue -> WAIT_2; wb -> ALU.
REQ-044 Fill all 4 slots, then id_ack -> id_feed=0, no capture; slot 0 issues to FREE and id_ack same cycle -> capture only next cycle.
REQ-045 Macro defined: allocate slots 0,1,2 ALU; free 0; allocate 0 ALU; sched_ack x4 -> issue order 1,2,0.
REQ-046 Macro undefined, same stimulus as REQ-045 -> issue order 0,1,2.
REQ-047 Stimulus: lsu_wb tag 2 while slot 2 is ALU, then flush -> first k16 unchanged; after flush all FREE, id_feed=1, r_ready=0.

Source files
------------

// File: rtl/station_pool.sv
// station_pool: reservation-station style pool of DEPTH issue entries.
// Decode allocates into the lowest-index FREE slot, load returns wake
// waiting entries, and one ready entry is offered to the scheduler.
// Optional macro STATION_POOL_AGE_ORDER_EN: when defined, an age matrix
// picks the oldest ready entry; otherwise the lowest-index ready entry wins.
module station_pool #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IOP_W = 32,
  localparam int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             flush,
  input  logic             id_ack,
  input  logic [IOP_W-1:0] id_iop,
  input  logic [2:0]       id_iop_init,
  input  logic [15:0]      id_pc,
  input  logic [15:0]      id_k16,
  output logic             id_feed,
  input  logic             lsu_wb,
  input  logic [TAG_W-1:0] lsu_tag,
  input  logic [15:0]      lsu_data,
  output logic             r_ready,
  output logic [TAG_W-1:0] r_slot,
  output logic [2:0]       r_status,
  output logic [IOP_W-1:0] r_iop,
  output logic [15:0]      r_pc,
  output logic [15:0]      r_k16,
  output logic             r_will_complete,
  input  logic             sched_ack
);

  typedef enum logic [2:0] {
    ST_FREE   = 3'b000,
    ST_WAIT_1 = 3'b001,
    ST_WAIT_2 = 3'b010,
    ST_WAIT_3 = 3'b011,
    ST_LOAD_0 = 3'b100,
    ST_LOAD_1 = 3'b101,
    ST_ALU    = 3'b110,
    ST_STORE  = 3'b111
  } st_t;

  st_t              status [DEPTH];
  logic [IOP_W-1:0] iop_q  [DEPTH];
  logic [15:0]      pc_q   [DEPTH];
  logic [15:0]      k16_q  [DEPTH];

  logic             free_any;
  logic [TAG_W-1:0] alloc_idx;
  logic             alloc;
  logic             sel_found;
  logic [TAG_W-1:0] sel_idx;
  logic             issue;
  logic [DEPTH-1:0] ready_vec;

  // Status an entry moves to when it is issued.
  function automatic st_t issue_target(input st_t st, input logic [IOP_W-1:0] op);
    st_t nx;
    nx = st;
    case (st)
      ST_LOAD_0: nx = ST_WAIT_1;
      ST_LOAD_1: nx = op[28] ? ST_FREE : ST_WAIT_2;
      ST_ALU:    nx = op[23] ? ST_STORE : ST_FREE;
      ST_STORE:  nx = ST_FREE;
      default:   nx = st;
    endcase
    return nx;
  endfunction

  // Free-slot search: lowest-index FREE entry at cycle start.
  always_comb begin
    free_any  = 1'b0;
    alloc_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (status[i] == ST_FREE && !free_any) begin
        free_any  = 1'b1;
        alloc_idx = TAG_W'(i);
      end
    end
  end

  assign id_feed = free_any;
  assign alloc   = free_any & id_ack & ~flush & (id_iop_init != 3'b000);

  // Ready vector straight from the status MSB.
  always_comb begin
    ready_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      ready_vec[i] = status[i][2];
  end

`ifdef STATION_POOL_AGE_ORDER_EN
  // older[j][n] = 1 means entry j was allocated before entry n.
  logic [DEPTH-1:0] older [DEPTH];
  logic [DEPTH-1:0] oldest_vec;

  // Age matrix update on allocation; cleared by flush and reset.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      for (int unsigned j = 0; j < DEPTH; j++) older[j] <= '0;
    end else if (flush) begin
      for (int unsigned j = 0; j < DEPTH; j++) older[j] <= '0;
    end else if (alloc) begin
      for (int unsigned j = 0; j < DEPTH; j++)
        if (status[j] != ST_FREE) older[j][alloc_idx] <= 1'b1;
      older[alloc_idx] <= '0;
    end
  end

  // Oldest-ready selection: no other ready entry is older than it.
  always_comb begin
    oldest_vec = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      oldest_vec[i] = ready_vec[i];
      for (int unsigned j = 0; j < DEPTH; j++)
        if (ready_vec[j] && older[j][i]) oldest_vec[i] = 1'b0;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (oldest_vec[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = TAG_W'(i);
      end
    end
  end
`else
  // Lowest-index ready selection.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ready_vec[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = TAG_W'(i);
      end
    end
  end
`endif

  // Output mux of the selected entry, all zero when nothing is ready.
  always_comb begin
    r_ready         = sel_found;
    r_slot          = '0;
    r_status        = '0;
    r_iop           = '0;
    r_pc            = '0;
    r_k16           = '0;
    r_will_complete = 1'b0;
    if (sel_found) begin
      r_slot          = sel_idx;
      r_status        = status[sel_idx];
      r_iop           = iop_q[sel_idx];
      r_pc            = pc_q[sel_idx];
      r_k16           = k16_q[sel_idx];
      r_will_complete = (issue_target(status[sel_idx], iop_q[sel_idx]) == ST_FREE);
    end
  end

  assign issue = sched_ack & sel_found;

  // Per-entry state: allocation, load wakeup and issue transitions.
  // Allocation only hits a FREE entry, so it never collides with wb/issue.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        status[i] <= ST_FREE;
        iop_q[i]  <= '0;
        pc_q[i]   <= '0;
        k16_q[i]  <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) status[i] <= ST_FREE;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alloc && alloc_idx == TAG_W'(i)) begin
          status[i] <= st_t'(id_iop_init);
          iop_q[i]  <= id_iop;
          pc_q[i]   <= id_pc;
          k16_q[i]  <= id_k16;
        end else begin
          case (status[i])
            ST_WAIT_1, ST_WAIT_2: begin
              if (lsu_wb && lsu_tag == TAG_W'(i)) begin
                status[i] <= (status[i] == ST_WAIT_1) ? ST_LOAD_1 : ST_ALU;
                k16_q[i]  <= lsu_data;
              end
            end
            ST_WAIT_3: status[i] <= ST_STORE;
            ST_LOAD_0, ST_LOAD_1, ST_ALU, ST_STORE: begin
              if (issue && sel_idx == TAG_W'(i))
                status[i] <= issue_target(status[i], iop_q[i]);
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_station_pool.sv
// Self-checking bench for station_pool (default parameters). Expected issue
// records are queued when the stimulus is driven and popped at each issue.
// Issue order follows STATION_POOL_AGE_ORDER_EN when that macro is defined.
module tb_station_pool;

  logic        clk = 1'b0;
  logic        a_rst = 1'b1;
  logic        flush = 1'b0;
  logic        id_ack = 1'b0;
  logic [31:0] id_iop = '0;
  logic [2:0]  id_iop_init = '0;
  logic [15:0] id_pc = '0;
  logic [15:0] id_k16 = '0;
  logic        id_feed;
  logic        lsu_wb = 1'b0;
  logic [1:0]  lsu_tag = '0;
  logic [15:0] lsu_data = '0;
  logic        r_ready;
  logic [1:0]  r_slot;
  logic [2:0]  r_status;
  logic [31:0] r_iop;
  logic [15:0] r_pc;
  logic [15:0] r_k16;
  logic        r_will_complete;
  logic        sched_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  slot;
    logic [2:0]  st;
    logic [31:0] iop;
    logic [15:0] pc;
    logic [15:0] k16;
    logic        wc;
  } exp_t;

  exp_t exp_q[$];

  station_pool #(.DEPTH(4), .IOP_W(32)) dut (
    .clk(clk), .a_rst(a_rst), .flush(flush),
    .id_ack(id_ack), .id_iop(id_iop), .id_iop_init(id_iop_init),
    .id_pc(id_pc), .id_k16(id_k16), .id_feed(id_feed),
    .lsu_wb(lsu_wb), .lsu_tag(lsu_tag), .lsu_data(lsu_data),
    .r_ready(r_ready), .r_slot(r_slot), .r_status(r_status),
    .r_iop(r_iop), .r_pc(r_pc), .r_k16(r_k16),
    .r_will_complete(r_will_complete), .sched_ack(sched_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [2:0] init, input logic [31:0] iop,
                       input logic [15:0] pc, input logic [15:0] k16);
    id_ack = 1'b1; id_iop_init = init; id_iop = iop; id_pc = pc; id_k16 = k16;
    step();
    id_ack = 1'b0;
  endtask

  task automatic expect_issue(input logic [1:0] slot, input logic [2:0] st,
                              input logic [31:0] iop, input logic [15:0] pc,
                              input logic [15:0] k16, input logic wc);
    exp_t e;
    e.slot = slot; e.st = st; e.iop = iop; e.pc = pc; e.k16 = k16; e.wc = wc;
    exp_q.push_back(e);
  endtask

  // Pop the next expected record, compare the offered entry, then issue it.
  task automatic issue_one(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_ready"}, 64'(r_ready), 64'd1);
      check({tag, "_slot"},  64'(r_slot), 64'(e.slot));
      check({tag, "_stat"},  64'(r_status), 64'(e.st));
      check({tag, "_iop"},   64'(r_iop), 64'(e.iop));
      check({tag, "_pc"},    64'(r_pc), 64'(e.pc));
      check({tag, "_k16"},   64'(r_k16), 64'(e.k16));
      check({tag, "_wc"},    64'(r_will_complete), 64'(e.wc));
    end
    sched_ack = 1'b1;
    step();
    sched_ack = 1'b0;
  endtask

  task automatic wb(input logic [1:0] tag, input logic [15:0] data);
    lsu_wb = 1'b1; lsu_tag = tag; lsu_data = data;
    step();
    lsu_wb = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_feed"},  64'(id_feed), 64'd1);
    check({tag, "_ready"}, 64'(r_ready), 64'd0);
    check({tag, "_slot"},  64'(r_slot), 64'd0);
    check({tag, "_stat"},  64'(r_status), 64'd0);
    check({tag, "_iop"},   64'(r_iop), 64'd0);
    check({tag, "_pc"},    64'(r_pc), 64'd0);
    check({tag, "_k16"},   64'(r_k16), 64'd0);
    check({tag, "_wc"},    64'(r_will_complete), 64'd0);
  endtask

  initial begin
    #12;
    check_idle("rst_hold");
    a_rst = 1'b0;
    step();
    check_idle("rst_rel");

    // ALU issue completes immediately
    alloc(3'b110, 32'h0000_0001, 16'h0100, 16'hAAAA);
    expect_issue(2'd0, 3'b110, 32'h0000_0001, 16'h0100, 16'hAAAA, 1'b1);
    issue_one("alu");
    check_idle("alu_freed");

    // load path: LOAD_0 -> WAIT_1 -> LOAD_1 -> WAIT_2 -> ALU -> FREE
    alloc(3'b100, 32'h0000_0002, 16'h0200, 16'h5555);
    expect_issue(2'd0, 3'b100, 32'h0000_0002, 16'h0200, 16'h5555, 1'b0);
    issue_one("ld0");
    check("w1_ready", 64'(r_ready), 64'd0);
    wb(2'd1, 16'hFFFF);
    check("w1_wb_other", 64'(r_ready), 64'd0);
    wb(2'd0, 16'h1234);
    expect_issue(2'd0, 3'b101, 32'h0000_0002, 16'h0200, 16'h1234, 1'b0);
    issue_one("ld1");
    check("w2_ready", 64'(r_ready), 64'd0);
    wb(2'd0, 16'h5678);
    expect_issue(2'd0, 3'b110, 32'h0000_0002, 16'h0200, 16'h5678, 1'b1);
    issue_one("ld_alu");
    check_idle("ld_done");

    // LOAD_1 with iop[28] frees; ALU with iop[23] goes to STORE
    alloc(3'b101, 32'h1000_0000, 16'h0210, 16'h0011);
    expect_issue(2'd0, 3'b101, 32'h1000_0000, 16'h0210, 16'h0011, 1'b1);
    issue_one("ld1_fin");
    alloc(3'b110, 32'h0080_0000, 16'h0220, 16'h0022);
    expect_issue(2'd0, 3'b110, 32'h0080_0000, 16'h0220, 16'h0022, 1'b0);
    expect_issue(2'd0, 3'b111, 32'h0080_0000, 16'h0220, 16'h0022, 1'b1);
    issue_one("alu_st");
    issue_one("st");
    // WAIT_3 becomes STORE one cycle later without any event
    alloc(3'b011, 32'h0000_0033, 16'h0230, 16'h0033);
    check("w3_ready", 64'(r_ready), 64'd0);
    step();
    expect_issue(2'd0, 3'b111, 32'h0000_0033, 16'h0230, 16'h0033, 1'b1);
    issue_one("w3_st");
    // init 000 captures nothing
    alloc(3'b000, 32'h0000_0044, 16'h0444, 16'h0444);
    check_idle("init0");

    // full pool: no capture while full, freed slot only visible next cycle
    alloc(3'b110, 32'h0, 16'h0010, 16'h0);
    alloc(3'b001, 32'h0, 16'h0011, 16'h0);
    alloc(3'b001, 32'h0, 16'h0012, 16'h0);
    alloc(3'b001, 32'h0, 16'h0013, 16'h0);
    check("full_feed", 64'(id_feed), 64'd0);
    alloc(3'b110, 32'h0, 16'h0099, 16'h0);
    check("full_nocap_slot", 64'(r_slot), 64'd0);
    check("full_nocap_pc", 64'(r_pc), 64'h0010);
    id_ack = 1'b1; id_iop_init = 3'b110; id_iop = 32'h0; id_pc = 16'h0077; id_k16 = 16'h0;
    sched_ack = 1'b1;
    check("same_feed", 64'(id_feed), 64'd0);
    step();
    sched_ack = 1'b0;
    check("same_nocap", 64'(r_ready), 64'd0);
    check("same_feed1", 64'(id_feed), 64'd1);
    step();
    id_ack = 1'b0;
    expect_issue(2'd0, 3'b110, 32'h0, 16'h0077, 16'h0, 1'b1);
    issue_one("late_cap");
    wb(2'd1, 16'hBEEF);
    check("wb1_slot", 64'(r_slot), 64'd1);
    check("wb1_stat", 64'(r_status), 64'b101);
    check("wb1_k16", 64'(r_k16), 64'hBEEF);
    // flush overrides a simultaneous allocation
    flush = 1'b1;
    id_ack = 1'b1; id_iop_init = 3'b110; id_pc = 16'h0066;
    step();
    flush = 1'b0; id_ack = 1'b0;
    check_idle("flush1");
    alloc(3'b110, 32'h0, 16'h0300, 16'h0);
    expect_issue(2'd0, 3'b110, 32'h0, 16'h0300, 16'h0, 1'b1);
    issue_one("post_flush");

    // wb to an ALU entry is ignored; flush then clears everything
    alloc(3'b001, 32'h0, 16'h0400, 16'h0);
    alloc(3'b001, 32'h0, 16'h0401, 16'h0);
    alloc(3'b110, 32'h0, 16'h0402, 16'hCAFE);
    wb(2'd2, 16'hDEAD);
    check("wb_alu_slot", 64'(r_slot), 64'd2);
    check("wb_alu_k16", 64'(r_k16), 64'hCAFE);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_idle("flush2");

    // arbitration order
    alloc(3'b110, 32'h0, 16'h00A0, 16'h0);
    alloc(3'b110, 32'h0, 16'h00A1, 16'h0);
    alloc(3'b110, 32'h0, 16'h00A2, 16'h0);
    expect_issue(2'd0, 3'b110, 32'h0, 16'h00A0, 16'h0, 1'b1);
    issue_one("ord_free0");
    alloc(3'b110, 32'h0, 16'h00B0, 16'h0);
`ifdef STATION_POOL_AGE_ORDER_EN
    expect_issue(2'd1, 3'b110, 32'h0, 16'h00A1, 16'h0, 1'b1);
    expect_issue(2'd2, 3'b110, 32'h0, 16'h00A2, 16'h0, 1'b1);
    expect_issue(2'd0, 3'b110, 32'h0, 16'h00B0, 16'h0, 1'b1);
`else
    expect_issue(2'd0, 3'b110, 32'h0, 16'h00B0, 16'h0, 1'b1);
    expect_issue(2'd1, 3'b110, 32'h0, 16'h00A1, 16'h0, 1'b1);
    expect_issue(2'd2, 3'b110, 32'h0, 16'h00A2, 16'h0, 1'b1);
`endif
    issue_one("ord_a");
    issue_one("ord_b");
    issue_one("ord_c");
    check("ord_none", 64'(r_ready), 64'd0);
    sched_ack = 1'b1;
    step();
    sched_ack = 1'b0;
    check_idle("ord_idle");

    // reset mid-operation drops in-flight entries
    alloc(3'b110, 32'h0000_0055, 16'h0555, 16'h0555);
    alloc(3'b001, 32'h0, 16'h0556, 16'h0);
    check("pre_rst_ready", 64'(r_ready), 64'd1);
    #2 a_rst = 1'b1;
    #1 check_idle("mid_rst");
    step();
    a_rst = 1'b0;
    step();
    check_idle("post_rst");
    wb(2'd1, 16'h7777);
    check_idle("post_rst_wb");

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
